mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory request/response port between NUM_REQ cache clients (icache/dcache per core).
//  Grants one client at a time for a whole fill burst, so a client's line-fill beats are never interleaved with another's.
//  Routes memory responses back to the burst owner. Sits between the caches' mem_req/req_grant/mem_rsp and the memory controller.
//  Round-robin between clients, switching only at burst boundaries.
// PARAMETERS
//  NUM_REQ   2   number of client ports (>=2)
//  MAX_BURST 32  largest accepted burst length; matches CACHE_BLOCK_SIZE
// PORTS
//  clk          in   1                        clock
//  reset        in   1                        synchronous, active-high reset
//  cl_req       in   request_t [NUM_REQ]      client requests (cache mem_req)
//  cl_grant     out  [NUM_REQ]                per-client accept; beat taken when cl_req[i].vld && cl_grant[i]
//  cl_rsp       out  request_t [NUM_REQ]      routed memory responses
//  mem_req      out  request_t                request to memory
//  mem_ready    in   1                        memory accepts mem_req this cycle
//  mem_rsp      in   request_t                response from memory
//  owner        out  [$clog2(NUM_REQ)]        current burst owner
//  owner_vld    out  1                        a burst is in progress (state != IDLE)
//  proto_err    out  1                        sticky; set when a response arrives in IDLE
// BEHAVIOUR
//  Reset (reset==1 at posedge):
//   - State goes to IDLE; rr_ptr=0; owner=0; beat_cnt=0; rsp_cnt=0; proto_err=0.
//   - All outputs are 0 (all request_t fields).
//   - Mid-burst reset abandons the burst; no further beats or responses are forwarded.
//  State machine:
//   - IDLE:
//     - Pick the first i with cl_req[i].vld, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//     - Register owner=i and burst_len = (access_length==0) ? 1 : min(access_length, MAX_BURST).
//     - Go to BURST. No grant is given in the decision cycle: 1-cycle arbitration latency.
//   - BURST:
//     - Combinational pass-through: mem_req = cl_req[owner]; cl_grant[owner] = mem_ready.
//     - All other cl_grant are 0.
//     - beat_cnt increments on mem_req.vld && mem_ready.
//     - When the beat that makes beat_cnt==burst_len is accepted, go to DRAIN.
//     - mem_req is forced to 0 in DRAIN.
//   - DRAIN:
//     - Wait until rsp_cnt==burst_len.
//     - Then go to IDLE, set rr_ptr=(owner+1)%NUM_REQ, clear both counters.
//  Response routing (BURST and DRAIN):
//   - cl_rsp[owner] = mem_rsp combinationally; other cl_rsp are 0.
//   - rsp_cnt increments on mem_rsp.vld, saturating at burst_len.
//   - Responses may arrive during BURST. A response in the same cycle as the last request beat is counted.
//  Response in IDLE:
//   - mem_rsp.vld in IDLE is dropped (no cl_rsp.vld) and sets proto_err.
//   - proto_err clears only on reset.
//  Request withdrawal in BURST:
//   - If cl_req[owner].vld drops before the burst completes, the arbiter holds ownership and waits.
//   - No other client is granted until the burst completes.
//  Fairness:
//   - A client that just finished cannot win again while another client has vld high.
//  Widths:
//   - beat_cnt and rsp_cnt are $clog2(MAX_BURST)+1 bits; they never wrap.
// TESTING
//  T1: client0 alone, access_length=32, mem_ready=1.
//      -> 32 grants in 32 consecutive cycles starting 1 cycle after vld.
//      -> 32 rsps routed to cl_rsp[0]; back to IDLE after the 32nd rsp.
//  T2: client0 and client1 both vld in the same cycle, rr_ptr=0.
//      -> client0 serviced fully (32 beats + 32 rsps), then client1.
//      -> No cl_grant[1] before the client0 DRAIN completes.
//  T3: mem_ready toggles 1/0 every cycle, access_length=4.
//      -> Exactly 4 beats accepted; mem_req held stable while mem_ready=0.
//  T4: access_length=0 single read.
//      -> 1 beat, 1 rsp; rr_ptr advances to 1.
//  T5: reset asserted after 10 beats of a 32-beat burst.
//      -> Next cycle all outputs 0, owner_vld=0.
//      -> A new request after reset is granted to client0 first.
//  T6: mem_rsp.vld pulsed while IDLE.
//      -> No cl_rsp.vld; proto_err=1, stays 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request/response port between cache clients.
// Ownership is held for a whole burst (requests plus their responses) so fills never interleave.
package mem_port_arbiter_pkg;
  localparam int AL_W = 8;

  typedef struct packed {
    logic            vld;
    logic            we;
    logic [AL_W-1:0] access_length;
    logic [31:0]     addr;
    logic [31:0]     data;
  } request_t;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  request_t                   cl_req [NUM_REQ],
  output logic [NUM_REQ-1:0]         cl_grant,
  output request_t                   cl_rsp [NUM_REQ],
  output request_t                   mem_req,
  input  logic                       mem_ready,
  input  request_t                   mem_rsp,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       owner_vld,
  output logic                       proto_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   rsp_q, rsp_d;
  logic            perr_q, perr_d;

  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic [AL_W-1:0] pick_al;
  logic [CW-1:0]   pick_len;
  logic            rsp_inc;

  // Scan downwards so the lowest rotated offset (closest to rr_q) wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [OW-1:0] idx;
      idx = OW'((int'(rr_q) + k) % NUM_REQ);
      if (cl_req[idx].vld) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_al = cl_req[pick].access_length;
    if (pick_al == '0) begin
      pick_len = CW'(1);
    end else if (int'(pick_al) > MAX_BURST) begin
      pick_len = CW'(MAX_BURST);
    end else begin
      pick_len = CW'(pick_al);
    end
  end

  always_comb begin
    mem_req = '0;
    if (state_q == BURST) begin
      mem_req = cl_req[owner_q];
    end
  end

  // Responses beyond the burst length are still routed but no longer counted.
  assign rsp_inc = mem_rsp.vld && (rsp_q != len_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    rsp_d   = rsp_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (mem_rsp.vld) begin
          perr_d = 1'b1;
        end
        if (pick_vld) begin
          owner_d = pick;
          len_d   = pick_len;
          state_d = BURST;
        end
      end
      BURST: begin
        if (rsp_inc) begin
          rsp_d = rsp_q + CW'(1);
        end
        if (mem_req.vld && mem_ready) begin
          beat_d = beat_q + CW'(1);
          if ((beat_q + CW'(1)) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rsp_q == len_q) begin
          state_d = IDLE;
          rr_d    = OW'((int'(owner_q) + 1) % NUM_REQ);
          beat_d  = '0;
          rsp_d   = '0;
        end else if (rsp_inc) begin
          rsp_d = rsp_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rsp_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rsp_q   <= rsp_d;
      perr_q  <= perr_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
    assign cl_grant[gi] = (state_q == BURST) && (owner_q == OW'(gi)) && mem_ready;
    assign cl_rsp[gi]   = ((state_q != IDLE) && (owner_q == OW'(gi))) ? mem_rsp : '0;
  end

  assign owner     = owner_q;
  assign owner_vld = (state_q != IDLE);
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: client/memory BFMs, a per-cycle reference model
// derived from the arbitration rules, and literal checks for each scenario.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int MB = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  request_t       cl_req [N];
  logic [N-1:0]   cl_grant;
  request_t       cl_rsp [N];
  request_t       mem_req;
  logic           mem_ready = 1'b1;
  request_t       mem_rsp = '0;
  logic [0:0]     owner;
  logic           owner_vld;
  logic           proto_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cl_req    (cl_req),
    .cl_grant  (cl_grant),
    .cl_rsp    (cl_rsp),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .mem_rsp   (mem_rsp),
    .owner     (owner),
    .owner_vld (owner_vld),
    .proto_err (proto_err)
  );

  int tests = 0;
  int fails = 0;

  int        remain [N] = '{0, 0};
  logic [7:0] alen  [N] = '{8'd0, 8'd0};
  int        ready_mode = 0;
  bit        inject = 1'b0;
  int        rsp_seq = 1;

  int beats_acc [N] = '{0, 0};
  int rsps_got  [N] = '{0, 0};
  int cyc = 0;
  int first_vld_cyc = -1;
  int first_grant_cyc = -1;
  int last_grant_cyc = -1;
  int first_grant_client = -1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Client and memory BFM: beats sampled at negedge, inputs updated 1 time unit after posedge.
  initial begin
    bit acc [N];
    bit any_acc;
    bit fire;
    bit pipe [$];
    pipe = '{1'b0, 1'b0};
    for (int i = 0; i < N; i++) begin
      cl_req[i] = '0;
      cl_req[i].addr = 32'h1000 * (i + 1);
      cl_req[i].data = 32'hA000 + i;
    end
    forever begin
      @(negedge clk);
      any_acc = 1'b0;
      for (int i = 0; i < N; i++) begin
        acc[i] = cl_req[i].vld && cl_grant[i];
        any_acc |= acc[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && remain[i] > 0) begin
          remain[i]--;
          cl_req[i].addr = cl_req[i].addr + 4;
        end
        cl_req[i].vld = (remain[i] > 0);
        cl_req[i].access_length = alen[i];
      end
      pipe.push_back(any_acc);
      fire = pipe.pop_front();
      if (reset) begin
        pipe = '{1'b0, 1'b0};
        fire = 1'b0;
      end
      mem_rsp = '0;
      if (fire || inject) begin
        mem_rsp.vld = 1'b1;
        mem_rsp.data = rsp_seq;
        rsp_seq++;
      end
      mem_ready = (ready_mode != 0) ? ~mem_ready : 1'b1;
    end
  end

  // Reference model: phase 0 = idle, 1 = issuing beats, 2 = waiting for responses.
  initial begin
    int m_phase = 0, m_own = 0, m_len = 0, m_beats = 0, m_rsps = 0, m_rr = 0;
    bit m_perr = 1'b0;
    bit prev_stall = 1'b0;
    request_t prev_req;
    request_t exp_mreq;
    request_t exp_rsp;
    logic [N-1:0] exp_grant;
    int al;
    forever begin
      @(negedge clk);
      exp_mreq  = (m_phase == 1) ? cl_req[m_own] : '0;
      exp_grant = '0;
      if (m_phase == 1) exp_grant[m_own] = mem_ready;
      chk("owner_vld", owner_vld, (m_phase != 0));
      chk("owner", owner, m_own);
      chk("proto_err", proto_err, m_perr);
      chk("mem_req", mem_req, exp_mreq);
      chk("cl_grant", cl_grant, exp_grant);
      for (int i = 0; i < N; i++) begin
        exp_rsp = (m_phase != 0 && i == m_own) ? mem_rsp : '0;
        chk($sformatf("cl_rsp[%0d]", i), cl_rsp[i], exp_rsp);
      end
      if (prev_stall && m_phase == 1) chk("hold_while_stalled", mem_req, prev_req);
      prev_stall = (m_phase == 1) && cl_req[m_own].vld && !mem_ready;
      prev_req   = cl_req[m_own];

      for (int i = 0; i < N; i++) begin
        if (cl_req[i].vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (cl_req[i].vld && cl_grant[i]) begin
          beats_acc[i]++;
          if (first_grant_cyc < 0) first_grant_cyc = cyc;
          if (first_grant_client < 0) first_grant_client = i;
          last_grant_cyc = cyc;
        end
        if (cl_rsp[i].vld) rsps_got[i]++;
      end

      if (reset) begin
        m_phase = 0; m_own = 0; m_len = 0; m_beats = 0; m_rsps = 0; m_rr = 0; m_perr = 1'b0;
      end else begin
        case (m_phase)
          0: begin
            if (mem_rsp.vld) m_perr = 1'b1;
            for (int k = 0; k < N; k++) begin
              if (m_phase == 0 && cl_req[(m_rr + k) % N].vld) begin
                m_own = (m_rr + k) % N;
                al = int'(cl_req[m_own].access_length);
                m_len = (al == 0) ? 1 : ((al > MB) ? MB : al);
                m_phase = 1;
              end
            end
          end
          1: begin
            if (mem_rsp.vld && m_rsps < m_len) m_rsps++;
            if (cl_req[m_own].vld && mem_ready) m_beats++;
            if (m_beats == m_len) m_phase = 2;
          end
          default: begin
            if (m_rsps == m_len) begin
              m_phase = 0; m_rr = (m_own + 1) % N; m_beats = 0; m_rsps = 0;
            end else if (mem_rsp.vld) begin
              m_rsps++;
            end
          end
        endcase
      end
      cyc++;
    end
  end

  task automatic go(input int i, input int al, input int n);
    @(posedge clk);
    #2;
    alen[i] = al[7:0];
    remain[i] = n;
  endtask

  task automatic go_both(input int al0, input int n0, input int al1, input int n1);
    @(posedge clk);
    #2;
    alen[0] = al0[7:0]; remain[0] = n0;
    alen[1] = al1[7:0]; remain[1] = n1;
  endtask

  // Waits for one burst to start and then finish; an expired bound counts as a failure.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!owner_vld && n < 20);
    if (!owner_vld) chk({nm, "_start_timeout"}, 1'b0, 1'b1);
    n = 0;
    while (owner_vld && n < 400) begin @(negedge clk); n++; end
    if (owner_vld) chk({nm, "_done_timeout"}, 1'b1, 1'b0);
  endtask

  initial begin
    int b0, b1, r0, r1, n;
    repeat (3) @(negedge clk);
    chk("rst_owner_vld", owner_vld, 1'b0);
    chk("rst_grant", cl_grant, 2'b00);
    chk("rst_mem_req", mem_req, 74'd0);
    chk("rst_proto_err", proto_err, 1'b0);
    @(posedge clk); #2 reset = 1'b0;

    // T2: simultaneous requests, client0 first, client1 clamped from 40 to 32 beats.
    b0 = beats_acc[0]; b1 = beats_acc[1]; r0 = rsps_got[0]; r1 = rsps_got[1];
    go_both(32, 32, 40, 32);
    wait_done("T2a");
    chk("T2_c0_beats", beats_acc[0] - b0, 32);
    chk("T2_c0_rsps", rsps_got[0] - r0, 32);
    chk("T2_no_c1_grant", beats_acc[1] - b1, 0);
    wait_done("T2b");
    chk("T2_c1_beats", beats_acc[1] - b1, 32);
    chk("T2_c1_rsps", rsps_got[1] - r1, 32);

    // T4: zero length single read, then round-robin pointer must favour client1.
    b0 = beats_acc[0]; r0 = rsps_got[0];
    go(0, 0, 1);
    wait_done("T4");
    chk("T4_beats", beats_acc[0] - b0, 1);
    chk("T4_rsps", rsps_got[0] - r0, 1);
    first_grant_client = -1;
    go_both(1, 1, 1, 1);
    wait_done("T4b");
    chk("T4_rr_winner", first_grant_client, 1);
    wait_done("T4c");

    // T1: client0 alone, 32 back-to-back beats one cycle after request.
    b0 = beats_acc[0]; r0 = rsps_got[0];
    first_vld_cyc = -1; first_grant_cyc = -1;
    go(0, 32, 32);
    wait_done("T1");
    chk("T1_beats", beats_acc[0] - b0, 32);
    chk("T1_rsps", rsps_got[0] - r0, 32);
    chk("T1_latency", first_grant_cyc - first_vld_cyc, 1);
    chk("T1_consecutive", last_grant_cyc - first_grant_cyc, 31);

    // T3: mem_ready toggling, 4-beat burst.
    b1 = beats_acc[1];
    ready_mode = 1;
    go(1, 4, 4);
    wait_done("T3");
    ready_mode = 0;
    chk("T3_beats", beats_acc[1] - b1, 4);

    // T5: reset in the middle of a 32-beat burst.
    b0 = beats_acc[0];
    go(0, 32, 32);
    n = 0;
    while ((beats_acc[0] - b0) < 10 && n < 200) begin @(negedge clk); n++; end
    chk("T5_reached_10", (beats_acc[0] - b0) >= 10, 1'b1);
    @(posedge clk); #2 reset = 1'b1; remain[0] = 0;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("T5_owner_vld", owner_vld, 1'b0);
    chk("T5_grant", cl_grant, 2'b00);
    chk("T5_mem_req", mem_req, 74'd0);
    chk("T5_cl_rsp0", cl_rsp[0], 74'd0);
    chk("T5_owner", owner, 1'b0);
    first_grant_client = -1;
    go_both(4, 4, 4, 4);
    wait_done("T5b");
    chk("T5_c0_first", first_grant_client, 0);
    wait_done("T5c");

    // T6: response while idle is dropped and latches proto_err until reset.
    r0 = rsps_got[0] + rsps_got[1];
    @(posedge clk); #2 inject = 1'b1;
    @(posedge clk); #2 inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("T6_dropped", rsps_got[0] + rsps_got[1] - r0, 0);
    chk("T6_proto_err", proto_err, 1'b1);
    go(1, 2, 2);
    wait_done("T6b");
    chk("T6_sticky", proto_err, 1'b1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("T6_cleared", proto_err, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
